uart_mem_arbiter: RTL and testbench

- Shares one UART link (the uart_trans send/receive FIFO interface) between two memory requesters: port 0 = instruction fetch, port 1 = data memory.
- Serialises each granted request into a byte packet for the host, collects the host's response bytes, and returns read data or write-ack to the owning port.
- Sits between the CPU's IF/MEM stages and uart_trans. Exactly one transaction is in flight at a time.

---
 rtl/uart_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_uart_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_arbiter.sv
// Two-port memory arbiter that tunnels IF/MEM requests over a shared UART byte
// stream: one packet out per granted request, one response back, one done pulse.
module uart_mem_arbiter #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_mask,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_mask,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        send_flag,
  output logic [7:0]  send_data,
  input  logic        sendable,
  output logic        recv_flag,
  input  logic [7:0]  recv_data,
  input  logic        receivable
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_HDR, SEND_ADDR, SEND_DATA, WAIT_RESP, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            id_q, id_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     shift_q, shift_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata0_q, rdata0_d;
  logic [31:0]     rdata1_q, rdata1_d;
  logic            grant;
  logic            fin;
  logic [31:0]     resp_val;

  // NOTE: every comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    tcnt_d       = '0;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    send_flag    = 1'b0;
    send_data    = 8'h00;
    recv_flag    = 1'b0;
    grant        = 1'b0;
    fin          = 1'b0;
    resp_val     = '0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the port that did not win last time gets the link.
          grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          last_grant_d = grant;
          id_d         = grant;
          we_d         = grant ? req1_we    : req0_we;
          addr_d       = grant ? req1_addr  : req0_addr;
          wdata_d      = grant ? req1_wdata : req0_wdata;
          mask_d       = grant ? req1_mask  : req0_mask;
          cnt_d        = '0;
          shift_d      = '0;
          state_d      = SEND_HDR;
        end
      end
      SEND_HDR: begin
        send_flag = sendable;
        send_data = {id_q, we_q, 2'b00, mask_q};
        if (sendable) state_d = SEND_ADDR;
      end
      SEND_ADDR: begin
        send_flag = sendable;
        send_data = addr_q[{cnt_q, 3'b000} +: 8];
        if (sendable) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = we_q ? SEND_DATA : WAIT_RESP;
        end
      end
      SEND_DATA: begin
        send_flag = sendable;
        send_data = wdata_q[{cnt_q, 3'b000} +: 8];
        if (sendable) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        recv_flag = receivable;
        if (receivable) begin
          shift_d[{cnt_q, 3'b000} +: 8] = recv_data;
          cnt_d = cnt_q + 2'd1;
          // A write is answered by a single ack byte whose value is irrelevant.
          if (we_q || cnt_q == 2'd3) begin
            state_d  = DONE;
            fin      = 1'b1;
            err_d    = 1'b0;
            resp_val = we_q ? (id_q ? rdata1_q : rdata0_q) : shift_d;
          end
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == TW'(TIMEOUT)) begin
            state_d  = DONE;
            fin      = 1'b1;
            err_d    = 1'b1;
            resp_val = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      if (id_q) rdata1_d = resp_val;
      else      rdata0_d = resp_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      tcnt_q       <= '0;
      err_q        <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tcnt_q       <= tcnt_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign req0_done  = (state_q == DONE) && !id_q;
  assign req1_done  = (state_q == DONE) &&  id_q;
  assign req0_err   = req0_done && err_q;
  assign req1_err   = req1_done && err_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter: a byte-log TX host and a queued RX host
// around the DUT, a vector table for single transactions, hand-written corner cases.
module tb_uart_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_mask, req1_mask;
  logic        req0_done, req1_done, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        send_flag, recv_flag, sendable, receivable;
  logic [7:0]  send_data, recv_data;

  always #5 CLK = ~CLK;

  uart_mem_arbiter #(.TIMEOUT(20)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_mask(req0_mask), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_mask(req1_mask), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable)
  );

  // Host side: TX bytes are logged, RX bytes come from a preloaded ring.
  logic [7:0] tx_mem [256];
  logic [7:0] rx_mem [256];
  int tx_cnt = 0, rx_wr = 0, rx_rd = 0;
  int d0_cnt = 0, d1_cnt = 0, overlap = 0;

  assign receivable = (rx_wr != rx_rd);
  assign recv_data  = rx_mem[rx_rd[7:0]];

  always @(posedge CLK) begin
    if (send_flag) begin
      tx_mem[tx_cnt[7:0]] <= send_data;
      tx_cnt <= tx_cnt + 1;
    end
    if (recv_flag) rx_rd <= rx_rd + 1;
    if (req0_done) d0_cnt <= d0_cnt + 1;
    if (req1_done) d1_cnt <= d1_cnt + 1;
    if (send_flag && recv_flag) overlap <= overlap + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[7:0]] = b;
    rx_wr++;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) push_rx(w[8*j +: 8]);
  endtask

  task automatic drive_req(input bit p, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] m);
    if (p) begin
      req1_we = we; req1_addr = a; req1_wdata = wd; req1_mask = m; req1_valid = 1'b1;
    end else begin
      req0_we = we; req0_addr = a; req0_wdata = wd; req0_mask = m; req0_valid = 1'b1;
    end
  endtask

  task automatic release_req(input bit p);
    if (p) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic wait_done(input bit p, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      cyc++;
      if (p ? req1_done : req0_done) seen = 1'b1;
    end
  endtask

  task automatic wait_tx(input int target, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (tx_cnt == target) seen = 1'b1;
    end
  endtask

  task automatic check_pkt(input string name, input int start, input logic [7:0] hdr,
                           input logic [31:0] a, input logic [31:0] wd, input bit we);
    logic [7:0] exp_b [9];
    int len;
    len = we ? 9 : 5;
    exp_b[0] = hdr;
    for (int j = 0; j < 4; j++) begin
      exp_b[1+j] = a[8*j +: 8];
      exp_b[5+j] = wd[8*j +: 8];
    end
    check({name, "_len"}, 64'(tx_cnt - start), 64'(len));
    for (int j = 0; j < len; j++)
      check($sformatf("%s_byte%0d", name, j), 64'(tx_mem[(start + j) % 256]), 64'(exp_b[j]));
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] resp;
    logic [7:0]  exp_hdr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  start, cyc, n, rem0, rem1, d0b, d1b;
    bit  seen, got;
    logic [7:0] eb;

    vecs[0] = '{0, 0, 32'h0000_1004, 32'h0,         4'hF, 32'h1234_5678, 8'h0F, 32'h1234_5678};
    vecs[1] = '{1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 32'h0000_005A, 8'hC3, 32'h6666_6666};
    vecs[2] = '{1, 0, 32'h8000_0000, 32'h0,         4'h1, 32'hCAFE_F00D, 8'h81, 32'hCAFE_F00D};
    vecs[3] = '{0, 1, 32'hFFFF_FFFC, 32'h0102_0304, 4'hC, 32'h0000_00FF, 8'h4C, 32'h1234_5678};
    vecs[4] = '{1, 1, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0001, 8'hC0, 32'hCAFE_F00D};
    vecs[5] = '{0, 0, 32'h0000_ABCD, 32'h0,         4'h5, 32'h00FF_00FF, 8'h05, 32'h00FF_00FF};

    RST = 1'b1; sendable = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_mask = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_mask = 0;
    repeat (3) @(negedge CLK);
    check("rst_ctrl", {send_flag, send_data, recv_flag, req0_done, req1_done, req0_err, req1_err}, 0);
    check("rst_rdata", {req0_rdata, req1_rdata}, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_ctrl", {send_flag, recv_flag, req0_done, req1_done}, 0);

    // Both ports compete from reset, three reads each: grants must alternate 0,1,...
    start = tx_cnt;
    for (int t = 0; t < 6; t++) begin
      eb = 8'(8'h11 * (t + 1));
      push_word({4{eb}});
    end
    drive_req(0, 0, 32'h0000_0100, 0, 4'hF);
    drive_req(1, 0, 32'h0000_0200, 0, 4'hF);
    n = 0; rem0 = 3; rem1 = 3;
    for (int i = 0; i < 300 && n < 6; i++) begin
      @(negedge CLK);
      if (req0_done || req1_done) begin
        got = req1_done;
        eb  = 8'(8'h11 * (n + 1));
        check($sformatf("arb_port%0d", n), 64'(got), 64'(n % 2));
        check($sformatf("arb_rdata%0d", n), got ? req1_rdata : req0_rdata, {4{eb}});
        check("arb_single_done", 64'(req0_done & req1_done), 0);
        n++;
        if (got) begin rem1--; if (rem1 == 0) release_req(1); end
        else     begin rem0--; if (rem0 == 0) release_req(0); end
      end
    end
    check("arb_count", 64'(n), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("arb_hdr%0d_id", k), 64'(tx_mem[(start + 5*k) % 256][7]), 64'(k % 2));
    repeat (2) @(negedge CLK);

    foreach (vecs[v]) begin
      start = tx_cnt; d0b = d0_cnt; d1b = d1_cnt;
      if (vecs[v].we) push_rx(vecs[v].resp[7:0]);
      else            push_word(vecs[v].resp);
      drive_req(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].mask);
      wait_done(vecs[v].port, cyc, seen);
      check($sformatf("v%0d_done_seen", v), 64'(seen), 1);
      check($sformatf("v%0d_latency", v), 64'(cyc), vecs[v].we ? 64'd11 : 64'd10);
      check($sformatf("v%0d_rdata", v), vecs[v].port ? req1_rdata : req0_rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d_err", v), 64'(vecs[v].port ? req1_err : req0_err), 0);
      check($sformatf("v%0d_other_done", v), 64'(vecs[v].port ? req0_done : req1_done), 0);
      release_req(vecs[v].port);
      repeat (2) @(negedge CLK);
      check_pkt($sformatf("v%0d_pkt", v), start, vecs[v].exp_hdr, vecs[v].addr,
                vecs[v].wdata, vecs[v].we);
      check($sformatf("v%0d_dones", v), {32'(d0_cnt - d0b), 32'(d1_cnt - d1b)},
            vecs[v].port ? {32'd0, 32'd1} : {32'd1, 32'd0});
    end

    // TX FIFO full for 5 cycles after the first address byte.
    start = tx_cnt;
    push_word(32'h1234_5678);
    drive_req(0, 0, 32'h0000_1004, 0, 4'hF);
    wait_tx(start + 2, seen);
    check("stall_reach", 64'(seen), 1);
    sendable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_flag%0d", i), 64'(send_flag), 0);
      @(negedge CLK);
    end
    check("stall_no_push", 64'(tx_cnt - start), 2);
    sendable = 1'b1;
    wait_done(0, cyc, seen);
    check("stall_done_seen", 64'(seen), 1);
    check("stall_rdata", req0_rdata, 32'h1234_5678);
    release_req(0);
    repeat (2) @(negedge CLK);
    check_pkt("stall_pkt", start, 8'h0F, 32'h0000_1004, 0, 0);

    // No response: 1 hdr + 4 addr cycles, 20 empty WAIT_RESP cycles, then DONE.
    start = tx_cnt;
    drive_req(0, 0, 32'h0000_0040, 0, 4'hF);
    wait_done(0, cyc, seen);
    check("to_done_seen", 64'(seen), 1);
    check("to_latency", 64'(cyc), 26);
    check("to_err", 64'(req0_err), 1);
    check("to_rdata", req0_rdata, 0);
    release_req(0);
    repeat (2) @(negedge CLK);
    check("to_pkt_len", 64'(tx_cnt - start), 5);

    push_word(32'hA5A5_0001);
    drive_req(1, 0, 32'h0000_0080, 0, 4'hF);
    wait_done(1, cyc, seen);
    check("after_to_seen", 64'(seen), 1);
    check("after_to_latency", 64'(cyc), 10);
    check("after_to_rdata", req1_rdata, 32'hA5A5_0001);
    check("after_to_err", 64'(req1_err), 0);
    release_req(1);
    repeat (2) @(negedge CLK);
    check("after_to_rdata0_held", req0_rdata, 0);

    // Reset in the middle of the write-data bytes.
    start = tx_cnt; d0b = d0_cnt;
    drive_req(0, 1, 32'h0000_0010, 32'h55AA_55AA, 4'hF);
    wait_tx(start + 6, seen);
    check("rst_reach", 64'(seen), 1);
    RST = 1'b1;
    #1;
    check("midrst_ctrl", {send_flag, send_data, recv_flag, req0_done, req1_done, req0_err, req1_err}, 0);
    check("midrst_rdata", {req0_rdata, req1_rdata}, 0);
    release_req(0);
    repeat (3) @(negedge CLK);
    check("midrst_no_push", 64'(tx_cnt - start), 6);
    check("midrst_no_done", 64'(d0_cnt - d0b), 0);
    RST = 1'b0;
    @(negedge CLK);
    start = tx_cnt;
    push_word(32'h0BAD_F00D);
    drive_req(0, 0, 32'h2000_0000, 0, 4'hF);
    wait_done(0, cyc, seen);
    check("post_rst_seen", 64'(seen), 1);
    check("post_rst_latency", 64'(cyc), 10);
    check("post_rst_rdata", req0_rdata, 32'h0BAD_F00D);
    release_req(0);
    repeat (2) @(negedge CLK);
    check_pkt("post_rst_pkt", start, 8'h0F, 32'h2000_0000, 0, 0);

    check("no_send_recv_overlap", 64'(overlap), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
